// File: rtl/alu_seq_pkg.sv
// Shared ALU definitions: opcodes, status bit positions and per-op flag masks.
// Used by the sequencer, the flag merge and the ALU itself.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADC  = 4'd1,
    OP_SBC  = 4'd2,
    OP_AND  = 4'd3,
    OP_EOR  = 4'd4,
    OP_ORA  = 4'd5,
    OP_BIT  = 4'd6,
    OP_ASL  = 4'd7,
    OP_LSR  = 4'd8,
    OP_ROL  = 4'd9,
    OP_ROR  = 4'd10,
    OP_PASS = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    MEMWR
  } seq_state_e;

  typedef enum int unsigned {
    FLAG_N = 0,
    FLAG_V = 1,
    FLAG_B = 3,
    FLAG_D = 4,
    FLAG_I = 5,
    FLAG_Z = 6,
    FLAG_C = 7
  } flag_idx_e;

  localparam logic [7:0] BIT_C = 8'(8'd1 << FLAG_C);
  localparam logic [7:0] BIT_Z = 8'(8'd1 << FLAG_Z);
  localparam logic [7:0] BIT_I = 8'(8'd1 << FLAG_I);
  localparam logic [7:0] BIT_V = 8'(8'd1 << FLAG_V);
  localparam logic [7:0] BIT_N = 8'(8'd1 << FLAG_N);

  localparam logic [7:0] P_RESET    = BIT_I;
  localparam logic [7:0] MASK_ARITH = BIT_C | BIT_Z | BIT_V | BIT_N;
  localparam logic [7:0] MASK_LOGIC = BIT_Z | BIT_N;
  localparam logic [7:0] MASK_SHIFT = BIT_C | BIT_Z | BIT_N;
  localparam logic [7:0] MASK_BIT   = BIT_Z | BIT_V | BIT_N;

  // Unassigned opcodes 12..15 behave exactly like PASS.
  function automatic alu_op_e norm_op(input logic [3:0] op);
    return (op > 4'd11) ? OP_PASS : alu_op_e'(op);
  endfunction

  function automatic logic [7:0] flag_mask_for(input alu_op_e op);
    case (op)
      OP_ADD, OP_ADC, OP_SBC:         return MASK_ARITH;
      OP_ASL, OP_LSR, OP_ROL, OP_ROR: return MASK_SHIFT;
      OP_BIT:                         return MASK_BIT;
      default:                        return MASK_LOGIC;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request, flag-write, ALU and memory-write signals of the ALU sequencer.
// The sequencer connects through the slave modport.
interface alu_seq_if;

  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op;
  logic [7:0] req_operand;
  logic       req_dst_mem;
  logic       flag_we;
  logic [7:0] flag_mask;
  logic [7:0] flag_val;
  logic [3:0] alu_op;
  logic [7:0] alu_operand;
  logic [7:0] alu_status;
  logic [7:0] alu_result;
  logic [7:0] alu_status_out;
  logic       mem_wr_valid;
  logic       mem_wr_ready;
  logic [7:0] mem_wr_data;
  logic [7:0] acc;
  logic [7:0] status;
  logic       done;

  modport slave (
    input  req_valid, req_op, req_operand, req_dst_mem,
    input  flag_we, flag_mask, flag_val,
    input  alu_result, alu_status_out, mem_wr_ready,
    output req_ready, alu_op, alu_operand, alu_status,
    output mem_wr_valid, mem_wr_data, acc, status, done
  );

  modport master (
    output req_valid, req_op, req_operand, req_dst_mem,
    output flag_we, flag_mask, flag_val,
    output alu_result, alu_status_out, mem_wr_ready,
    input  req_ready, alu_op, alu_operand, alu_status,
    input  mem_wr_valid, mem_wr_data, acc, status, done
  );

endinterface

// File: rtl/alu_seq_flag_merge.sv
// Combinational status merge: folds the ALU flags into P under the op's mask.
// BIT takes V and N straight from operand bits 6 and 7 instead of the ALU.
module alu_flag_merge
  import alu_seq_pkg::*;
(
  input  alu_op_e    i_op,
  input  logic [7:0] i_p,
  input  logic [7:0] i_alu_flags,
  input  logic [1:0] i_operand_hi,
  output logic [7:0] o_p
);

  logic [7:0] w_mask;
  logic [7:0] w_val;

  always_comb begin
    w_mask = flag_mask_for(i_op);
    w_val  = i_alu_flags;
    if (i_op == OP_BIT) begin
      w_val[FLAG_V] = i_operand_hi[0];
      w_val[FLAG_N] = i_operand_hi[1];
    end
    o_p = (i_p & ~w_mask) | (w_val & w_mask);
  end

endmodule

// File: rtl/alu_seq.sv
// Sequencer around an external ALU: accepts one op, issues it, captures the
// result into A or memory and merges the status flags into P.
module alu_seq
  import alu_seq_pkg::*;
(
  input logic     clk,
  input logic     rst,
  alu_seq_if.slave bus
);

  seq_state_e r_state;
  alu_op_e    r_alu_op;
  logic [7:0] r_operand;
  logic       r_dst_mem;
  logic [7:0] r_acc;
  logic [7:0] r_p;
  logic       r_done;
  logic       r_mem_valid;
  logic [7:0] r_mem_data;

  logic [7:0] w_p_flag_wr;
  logic [7:0] w_p_merged;

  assign w_p_flag_wr = (r_p & ~bus.flag_mask) | (bus.flag_val & bus.flag_mask);

  alu_flag_merge u_flag_merge (
    .i_op         (r_alu_op),
    .i_p          (r_p),
    .i_alu_flags  (bus.alu_status_out),
    .i_operand_hi (r_operand[7:6]),
    .o_p          (w_p_merged)
  );

  // P is written before the op issues, so a same-cycle SEC is seen by ADC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_alu_op    <= OP_PASS;
      r_operand   <= 8'h00;
      r_dst_mem   <= 1'b0;
      r_acc       <= 8'h00;
      r_p         <= P_RESET;
      r_done      <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_data  <= 8'h00;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.flag_we) begin
            r_p <= w_p_flag_wr;
          end
          if (bus.req_valid) begin
            r_alu_op  <= norm_op(bus.req_op);
            r_operand <= bus.req_operand;
            r_dst_mem <= bus.req_dst_mem;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_p      <= w_p_merged;
          r_alu_op <= OP_PASS;
          if (r_dst_mem) begin
            r_mem_data  <= bus.alu_result;
            r_mem_valid <= 1'b1;
            r_state     <= MEMWR;
          end else begin
            if (r_alu_op != OP_BIT) begin
              r_acc <= bus.alu_result;
            end
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        MEMWR: begin
          if (bus.mem_wr_ready) begin
            r_mem_valid <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.req_ready    = (r_state == IDLE);
  assign bus.alu_op       = r_alu_op;
  assign bus.alu_operand  = r_operand;
  assign bus.alu_status   = r_p;
  assign bus.status       = r_p;
  assign bus.acc          = r_acc;
  assign bus.done         = r_done;
  assign bus.mem_wr_valid = r_mem_valid;
  assign bus.mem_wr_data  = r_mem_data;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural ALU, directed vector table, reset-abort
// sequences and randomized ops checked against a flag-rule reference model.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst;

  alu_seq_if bus ();

  alu_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int testsRun  = 0;
  int failCount = 0;

  logic [7:0] modelA;
  logic [7:0] modelP;

  // ALU environment; bits an op does not define come back as ~P so a bad mask shows.
  function automatic logic [15:0] alu_model(input logic [3:0] opIn, input logic [7:0] a,
                                            input logic [7:0] b, input logic [7:0] p);
    logic [3:0] op;
    logic [8:0] sum;
    logic [7:0] res;
    logic [7:0] st;
    logic       c;
    logic       v;
    op  = (opIn > 4'd11) ? 4'd11 : opIn;
    sum = 9'd0;
    res = b;
    c   = p[7];
    v   = ~p[1];
    st  = ~p;
    case (op)
      4'd0: begin sum = {1'b0, a} + {1'b0, b}; res = sum[7:0]; c = sum[8];
                  v = (a[7] == b[7]) && (res[7] != a[7]); end
      4'd1: begin sum = {1'b0, a} + {1'b0, b} + {8'd0, p[7]}; res = sum[7:0]; c = sum[8];
                  v = (a[7] == b[7]) && (res[7] != a[7]); end
      4'd2: begin sum = {1'b0, a} + {1'b0, ~b} + {8'd0, p[7]}; res = sum[7:0]; c = sum[8];
                  v = (a[7] != b[7]) && (res[7] != a[7]); end
      4'd3: res = a & b;
      4'd4: res = a ^ b;
      4'd5: res = a | b;
      4'd6: res = a & b;
      4'd7: begin res = {b[6:0], 1'b0}; c = b[7]; end
      4'd8: begin res = {1'b0, b[7:1]}; c = b[0]; end
      4'd9: begin res = {b[6:0], p[7]}; c = b[7]; end
      4'd10: begin res = {p[7], b[7:1]}; c = b[0]; end
      default: res = b;
    endcase
    if (op <= 4'd2 || (op >= 4'd7 && op <= 4'd10)) st[7] = c;
    if (op <= 4'd2) st[1] = v;
    st[6] = (res == 8'h00);
    st[0] = res[7];
    return {res, st};
  endfunction

  assign {bus.alu_result, bus.alu_status_out} =
         alu_model(bus.alu_op, bus.acc, bus.alu_operand, bus.alu_status);

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic flagWrite(input logic [7:0] mask, input logic [7:0] val);
    bus.flag_we   = 1'b1;
    bus.flag_mask = mask;
    bus.flag_val  = val;
    @(negedge clk);
    bus.flag_we = 1'b0;
    modelP = (modelP & ~mask) | (val & mask);
    checkOutput("flag_write_status", bus.status, modelP);
  endtask

  // One full operation from IDLE back to IDLE; starts and ends on a negedge.
  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] opd, input logic dst,
                               input int memDelay, input logic fwe, input logic [7:0] fm,
                               input logic [7:0] fv, input logic noise,
                               output logic [7:0] gotA, output logic [7:0] gotP,
                               output logic [7:0] gotMem);
    logic [15:0] aluOut;
    logic [7:0]  res;
    logic [7:0]  st;
    logic [7:0]  expA;
    logic [7:0]  expP;
    logic [3:0]  nop;
    if (fwe) modelP = (modelP & ~fm) | (fv & fm);
    nop    = (op > 4'd11) ? 4'd11 : op;
    aluOut = alu_model(op, modelA, opd, modelP);
    res    = aluOut[15:8];
    st     = aluOut[7:0];
    expP   = modelP;
    case (nop)
      4'd0, 4'd1, 4'd2: begin expP[7] = st[7]; expP[6] = st[6]; expP[1] = st[1]; expP[0] = st[0]; end
      4'd7, 4'd8, 4'd9, 4'd10: begin expP[7] = st[7]; expP[6] = st[6]; expP[0] = st[0]; end
      4'd6: begin expP[6] = st[6]; expP[1] = opd[6]; expP[0] = opd[7]; end
      default: begin expP[6] = st[6]; expP[0] = st[0]; end
    endcase
    expA = (dst || nop == 4'd6) ? modelA : res;

    bus.req_valid   = 1'b1;
    bus.req_op      = op;
    bus.req_operand = opd;
    bus.req_dst_mem = dst;
    bus.flag_we     = fwe;
    bus.flag_mask   = fm;
    bus.flag_val    = fv;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flag_we   = 1'b0;
    checkOutput("issue_ready", bus.req_ready, 0);
    checkOutput("issue_op", bus.alu_op, 32'(nop));
    checkOutput("issue_operand", bus.alu_operand, 32'(opd));
    checkOutput("issue_status", bus.status, modelP);
    if (noise) begin
      bus.req_valid   = 1'b1;
      bus.req_op      = 4'($urandom);
      bus.req_operand = 8'($urandom);
      bus.req_dst_mem = 1'($urandom);
      bus.flag_we     = 1'b1;
      bus.flag_mask   = 8'($urandom);
      bus.flag_val    = 8'($urandom);
    end
    @(negedge clk);
    checkOutput("capture_op", bus.alu_op, 32'(nop));
    checkOutput("capture_ready", bus.req_ready, 0);
    checkOutput("capture_done", bus.done, 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flag_we   = 1'b0;
    checkOutput("commit_status", bus.status, expP);
    checkOutput("commit_acc", bus.acc, expA);
    checkOutput("commit_aluop_pass", bus.alu_op, 11);
    gotA   = bus.acc;
    gotP   = bus.status;
    gotMem = bus.mem_wr_data;
    if (!dst) begin
      checkOutput("commit_done", bus.done, 1);
      checkOutput("commit_ready", bus.req_ready, 1);
      checkOutput("commit_no_memwr", bus.mem_wr_valid, 0);
    end else begin
      checkOutput("memwr_valid", bus.mem_wr_valid, 1);
      checkOutput("memwr_data", bus.mem_wr_data, 32'(res));
      checkOutput("memwr_no_done", bus.done, 0);
      checkOutput("memwr_busy", bus.req_ready, 0);
      for (int k = 0; k < memDelay; k++) begin
        @(negedge clk);
        checkOutput("memwr_valid_held", bus.mem_wr_valid, 1);
        checkOutput("memwr_data_held", bus.mem_wr_data, 32'(res));
        checkOutput("memwr_wait_done", bus.done, 0);
      end
      bus.mem_wr_ready = 1'b1;
      @(negedge clk);
      bus.mem_wr_ready = 1'b0;
      checkOutput("memwr_done", bus.done, 1);
      checkOutput("memwr_released", bus.mem_wr_valid, 0);
      checkOutput("memwr_ready", bus.req_ready, 1);
      checkOutput("memwr_acc_kept", bus.acc, expA);
    end
    modelA = expA;
    modelP = expP;
    @(negedge clk);
    checkOutput("done_single", bus.done, 0);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] aInit;
    logic [7:0] preMask;
    logic [7:0] preVal;
    logic [7:0] simMask;
    logic [7:0] simVal;
    logic [7:0] operand;
    logic       dstMem;
    int         memDelay;
    logic [7:0] expA;
    logic [7:0] expMem;
    logic [7:0] chkMask;
    logic [7:0] chkVal;
  } vec_t;

  vec_t vecs[11];

  logic [7:0] gA;
  logic [7:0] gP;
  logic [7:0] gM;

  initial begin
    vecs[0]  = '{4'd1,  8'h50, 8'h80, 8'h00, 8'h00, 8'h00, 8'h50, 1'b0, 0, 8'hA0, 8'h00, 8'hE3, 8'h23};
    vecs[1]  = '{4'd2,  8'h05, 8'h80, 8'h80, 8'h00, 8'h00, 8'h03, 1'b0, 0, 8'h02, 8'h00, 8'hC3, 8'h80};
    vecs[2]  = '{4'd6,  8'h0F, 8'h80, 8'h80, 8'h00, 8'h00, 8'hC0, 1'b0, 0, 8'h0F, 8'h00, 8'hC3, 8'hC3};
    vecs[3]  = '{4'd7,  8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h81, 1'b1, 3, 8'h33, 8'h02, 8'hC1, 8'h80};
    vecs[4]  = '{4'd0,  8'hFF, 8'h80, 8'h80, 8'h00, 8'h00, 8'h01, 1'b0, 0, 8'h00, 8'h00, 8'hC3, 8'hC0};
    vecs[5]  = '{4'd10, 8'h44, 8'h80, 8'h80, 8'h00, 8'h00, 8'h01, 1'b0, 0, 8'h80, 8'h00, 8'hC1, 8'h81};
    vecs[6]  = '{4'd8,  8'h44, 8'h80, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 0, 8'h00, 8'h00, 8'hC1, 8'hC0};
    vecs[7]  = '{4'd13, 8'h44, 8'h82, 8'h82, 8'h00, 8'h00, 8'h80, 1'b0, 0, 8'h80, 8'h00, 8'hC3, 8'h83};
    vecs[8]  = '{4'd4,  8'hAA, 8'h80, 8'h00, 8'h00, 8'h00, 8'hAA, 1'b0, 0, 8'h00, 8'h00, 8'hC1, 8'h40};
    vecs[9]  = '{4'd9,  8'h12, 8'h80, 8'h00, 8'h00, 8'h00, 8'h80, 1'b1, 0, 8'h12, 8'h00, 8'hC1, 8'hC0};
    vecs[10] = '{4'd1,  8'h01, 8'h80, 8'h00, 8'h80, 8'h80, 8'h01, 1'b0, 0, 8'h03, 8'h00, 8'hC3, 8'h00};

    bus.req_valid    = 1'b0;
    bus.req_op       = 4'd0;
    bus.req_operand  = 8'h00;
    bus.req_dst_mem  = 1'b0;
    bus.flag_we      = 1'b0;
    bus.flag_mask    = 8'h00;
    bus.flag_val     = 8'h00;
    bus.mem_wr_ready = 1'b0;
    modelA           = 8'h00;
    modelP           = 8'h20;

    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_acc", bus.acc, 8'h00);
    checkOutput("reset_status", bus.status, 8'h20);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_memwr", bus.mem_wr_valid, 0);
    checkOutput("reset_memdata", bus.mem_wr_data, 8'h00);
    checkOutput("reset_aluop", bus.alu_op, 11);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", bus.req_ready, 1);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(4'd11, vecs[i].aInit, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0, gA, gP, gM);
      flagWrite(vecs[i].preMask, vecs[i].preVal);
      applyStimulus(vecs[i].op, vecs[i].operand, vecs[i].dstMem, vecs[i].memDelay,
                    (vecs[i].simMask != 8'h00), vecs[i].simMask, vecs[i].simVal, 1'b1, gA, gP, gM);
      checkOutput($sformatf("vec%0d_acc", i), gA, vecs[i].expA);
      checkOutput($sformatf("vec%0d_flags", i), gP & vecs[i].chkMask, vecs[i].chkVal);
      if (vecs[i].dstMem) checkOutput($sformatf("vec%0d_memdata", i), gM, vecs[i].expMem);
    end

    // Reset landing in CAPTURE must drop the op without any commit.
    applyStimulus(4'd11, 8'h5A, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0, gA, gP, gM);
    bus.req_valid   = 1'b1;
    bus.req_op      = 4'd1;
    bus.req_operand = 8'h11;
    bus.req_dst_mem = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_acc", bus.acc, 8'h00);
    checkOutput("abort_status", bus.status, 8'h20);
    checkOutput("abort_done", bus.done, 0);
    checkOutput("abort_memwr", bus.mem_wr_valid, 0);
    checkOutput("abort_aluop", bus.alu_op, 11);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_ready", bus.req_ready, 1);
    checkOutput("abort_no_done", bus.done, 0);
    modelA = 8'h00;
    modelP = 8'h20;

    // Reset while a memory write is still pending.
    bus.req_valid   = 1'b1;
    bus.req_op      = 4'd7;
    bus.req_operand = 8'h40;
    bus.req_dst_mem = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("memabort_pending", bus.mem_wr_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("memabort_valid", bus.mem_wr_valid, 0);
    checkOutput("memabort_data", bus.mem_wr_data, 8'h00);
    checkOutput("memabort_done", bus.done, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("memabort_ready", bus.req_ready, 1);
    modelA = 8'h00;
    modelP = 8'h20;

    for (int i = 0; i < 150; i++) begin
      applyStimulus(4'($urandom_range(15, 0)), 8'($urandom), 1'($urandom_range(1, 0)),
                    int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 8'($urandom),
                    8'($urandom), 1'($urandom_range(1, 0)), gA, gP, gM);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have these ports, clock and reset first:
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  operation request.
- req_ready  out  1  high only in IDLE.
- req_op  in  4  ALU opcode: ADD=0, ADC=1, SBC=2, AND=3, EOR=4, ORA=5, BIT=6, ASL=7, LSR=8, ROL=9, ROR=10, PASS=11.
- req_operand  in  8  second operand.
- req_dst_mem  in  1  1 = write result to memory; 0 = write result to accumulator.
- flag_we  in  1  direct status write (SEC/CLC/SEI/...).
- flag_mask  in  8  status bits to modify.
- flag_val  in  8  new values for masked bits.
- alu_op  out  4  to ALU.
- alu_operand  out  8  to ALU.
- alu_status  out  8  to ALU; always equals the P register.
- alu_result  in  8  from ALU.
- alu_status_out  in  8  from ALU: bit7 carry, bit6 zero, bit1 overflow, bit0 negative.
- mem_wr_valid  out  1  memory write request.
- mem_wr_ready  in  1  memory write accept.
- mem_wr_data  out  8  memory write data.
- acc  out  8  accumulator register A.
- status  out  8  status register P.
- done  out  1  one-cycle completion pulse.

Function
REQ-002 FSM states SHALL be IDLE, ISSUE, CAPTURE and MEMWR.
REQ-003 A request SHALL be accepted on a clock edge where req_valid & req_ready; op, operand and destination are latched and the FSM goes to ISSUE.
REQ-004 In ISSUE and CAPTURE, alu_op and alu_operand SHALL hold the latched values; in IDLE and MEMWR, alu_op SHALL be PASS.
REQ-005 ISSUE SHALL last 1 cycle and go to CAPTURE; CAPTURE SHALL last 1 cycle, sampling alu_result and alu_status_out at its closing edge.
REQ-006 On leaving CAPTURE with dst=A: A <= result (except BIT: A unchanged), P is updated, done=1 for the next cycle, and the FSM returns to IDLE. Accept at edge N gives done and the updated A/P in cycle N+3.
REQ-007 On leaving CAPTURE with dst=mem: P is updated, A is unchanged, mem_wr_data <= result, and the FSM goes to MEMWR.
REQ-008 In MEMWR, mem_wr_valid SHALL be 1 with mem_wr_data stable until mem_wr_ready; on that edge the FSM goes to IDLE and done=1 for the next cycle.
REQ-009 P update SHALL be a per-op masked merge:
- ADD/ADC/SBC: C, Z, V, N.
- AND/EOR/ORA/PASS: Z, N.
- ASL/LSR/ROL/ROR: C, Z, N.
- BIT: Z from ALU; V = operand[6]; N = operand[7].
- Unmasked bits are preserved.
REQ-010 An opcode of 12..15 SHALL be treated as PASS.
REQ-011 flag_we SHALL be honoured only in IDLE: P <= (P & ~flag_mask) | (flag_val & flag_mask).
- It is ignored in all other states.
REQ-012 Simultaneous flag_we and request acceptance in IDLE SHALL both take effect; the issued op sees the updated P (e.g., SEC then ADC).
REQ-013 req_valid while busy SHALL be ignored; no queueing.
REQ-014 done SHALL be a single-cycle pulse and SHALL never coincide with req_ready=0 in the same cycle.

Reset
REQ-015 While rst=1 at a clock edge: FSM to IDLE, A=8'h00, P=8'h20 (interrupt_disable set), done=0, mem_wr_valid=0, alu_op=PASS, mem_wr_data=8'h00.
REQ-016 Reset in any state SHALL abort the operation with no A/P/memory commit; req_ready=1 in the first cycle after rst deasserts.

Structure
REQ-017 Opcode values, status bit indices (C=7, Z=6, I=5, D=4, B=3, V=1, N=0) and per-op flag masks SHALL live in a shared package also used by the ALU.
REQ-018 The flag merge SHALL be one combinational sub-module, alu_flag_merge; the FSM and registers stay in alu_seq.

Verification
REQ-019 ADC with A=0x50, operand=0x50, C=0 -> cycle N+3: A=0xA0, C=0, Z=0, V=1, N=1, done pulse.
REQ-020 SBC with A=0x05, operand=0x03, C=1 -> A=0x02, C=1, Z=0, N=0.
REQ-021 BIT with A=0x0F, operand=0xC0 -> A=0x0F, Z=1, V=1, N=1, C unchanged.
REQ-022 ASL to mem with operand=0x81, mem_wr_ready low for 3 cycles -> mem_wr_valid held 3+ cycles, data 0x02, C=1, A unchanged; single done after the accept.
REQ-023 In IDLE, flag_we with mask=0x80, val=0x80 plus ADC request (A=0x01, operand=0x01) in the same cycle -> A=0x03.
REQ-024 rst asserted in CAPTURE -> A=0x00, P=0x20, no done, no mem_wr_valid, req_ready=1 next cycle.
